rice_encoder_packer: RTL and testbench
======================================

Name: rice_encoder_packer

Overview:
- Rice (fundamental-sequence + split) encoder and bit packer. It is the transmit-side counterpart of the decompression datapath.
- Each accepted sample is coded MSB-first as q = value>>k zeros, then a '1', then the k LSBs of the value.
- Codewords are packed into 32-bit words using a free-bit-length counter. This counter is the encoder-side mirror of the decoder's remaining-length/carry logic.
- Packed words go out on a valid/ready stream to the telemetry framer.

Parameters:
- DW, 16, sample width.
- KW, 4, width of k; k is valid from 0 to DW-1.
- QMAX, 31, largest legal quotient; unary chunk length q+1 never exceeds 32.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  sample offered.
- in_ready  output  1  block accepts the sample this cycle.
- in_data  input  DW  sample value, unsigned.
- in_k  input  KW  Rice parameter for this sample.
- flush  input  1  level request to pad and emit the partial word; held until flush_done.
- flush_done  output  1  one-cycle pulse when the flush completes.
- out_valid  output  1  out_data holds a packed word.
- out_ready  input  1  downstream accepts the word.
- out_data  output  32  packed word, first coded bit in bit 31.
- out_last  output  1  word was produced by a flush.
- err  output  1  one-cycle pulse when a sample is dropped because q > QMAX.

Behaviour:
- Reset is asynchronous and active-high:
  - state = IDLE, accumulator acc = 0, free count F = 32 (6-bit).
  - out_valid = 0, out_data = 0, out_last = 0, err = 0, flush_done = 0.
  - Reset mid-operation abandons the current sample and any partial word; no output is produced for them.
- FSM states: IDLE, UNARY, REM, FLUSH.
- IDLE:
  - in_ready = 1 only in IDLE.
  - in_valid has priority over flush. On acceptance, latch q, r = value & ((1<<k)-1), and k.
  - If q > QMAX: pulse err next cycle, emit nothing, stay in IDLE.
  - Otherwise go to UNARY.
  - If flush and !in_valid: go to FLUSH.
- UNARY: append n = q+1 bits, v = 1. Go to REM if k != 0, else to IDLE.
- REM: append n = k bits, v = r. Go to IDLE.
- Append rule, applied in one cycle:
  - n < F: acc |= v << (F-n); F -= n.
  - n == F: complete word = acc | v; acc = 0; F = 32.
  - n > F: complete word = acc | (v >> (n-F)); acc = v << (32-(n-F)); F = 32-(n-F).
- Completing a word requires the output slot to be free: out_valid == 0, or out_ready == 1 this cycle.
  - If the slot is not free, the phase stalls with no state change and retries next cycle.
  - A completed word loads out_data and sets out_valid = 1 on the next edge, with out_last = 0.
- Output handshake:
  - out_valid stays high until out_valid & out_ready.
  - out_data is stable while out_valid is high and out_ready is low.
- FLUSH:
  - If F == 32: pulse flush_done, return to IDLE, emit no word.
  - Otherwise wait for a free slot, then emit acc (pad bits are 0) with out_last = 1. Set acc = 0, F = 32, pulse flush_done, return to IDLE.
- Throughput and latency:
  - One sample every 2 cycles (k = 0) or 3 cycles (k > 0) without backpressure.
  - Word visible on out_valid one cycle after the completing append.
- Width rules: all shifts are in 32 bits; F and n are 6 bits; F ranges 1..32 and is never 0 after an edge.

Decomposition:
- Package rice_pkg: WORD_W = 32, LEN_W = 6, the FSM state enum, and the rice_enc_state_t typedef.
- Sub-module rice_word_appender (combinational):
  - Inputs: acc, F, v, n.
  - Outputs: next acc, next F, word_complete, completed word.
  - The FSM owns the registers and the stall logic.

Test Plan:
- Sample 5, k=1, then flush → bits 0011; single word 0x30000000 with out_last=1; flush_done pulse; F back to 32.
- 32 samples of value 0, k=0 → exactly one word 0xFFFFFFFF with out_last=0; a subsequent flush gives flush_done with no word.
- Value 0 k=0, then value 31 k=0 → word 0x80000000 (straddle, n=32 > F=31); flush → second word 0x80000000 with out_last=1.
- Value 64, k=1 (q=32) → err pulse, no word, acc/F unchanged; a following value 1 k=0 → normal output "01".
- Hold out_ready=0 while feeding 64 samples of value 0, k=0:
  - first word 0xFFFFFFFF is held stable;
  - the 64th append (completing the second word) stalls while the slot is full;
  - in_ready stays low after that;
  - releasing out_ready yields both 0xFFFFFFFF words in order with no loss.
- Assert reset during REM of sample 0xFFFF k=15 (q=1) → all outputs return to reset values immediately; after release, flush emits nothing.

Source files
------------

// File: rtl/rice_pkg.sv
// Shared widths, FSM state encodings and latched-sample record for the Rice encoder/packer.
package rice_pkg;

  localparam int WORD_W = 32;
  localparam int LEN_W  = 6;

  localparam logic [LEN_W-1:0] FREE_FULL = LEN_W'(WORD_W);

  typedef logic [1:0] rice_fsm_t;

  localparam rice_fsm_t S_IDLE  = 2'd0;
  localparam rice_fsm_t S_UNARY = 2'd1;
  localparam rice_fsm_t S_REM   = 2'd2;
  localparam rice_fsm_t S_FLUSH = 2'd3;

  // Sample fields captured at acceptance; r is already masked to k bits.
  typedef struct packed {
    logic [LEN_W-1:0]  q;
    logic [WORD_W-1:0] r;
    logic [LEN_W-1:0]  k;
  } rice_enc_state_t;

endpackage

// File: rtl/rice_word_appender.sv
// Combinational append of an n-bit chunk into the accumulator, MSB-first,
// producing a completed word when the chunk fills or straddles the free space.
module rice_word_appender
  import rice_pkg::*;
(
  input  logic [WORD_W-1:0] acc,
  input  logic [LEN_W-1:0]  free,
  input  logic [WORD_W-1:0] v,
  input  logic [LEN_W-1:0]  n,
  output logic [WORD_W-1:0] acc_next,
  output logic [LEN_W-1:0]  free_next,
  output logic              word_complete,
  output logic [WORD_W-1:0] word
);

  logic [LEN_W-1:0] spill;

  always_comb begin
    acc_next      = acc;
    free_next     = free;
    word_complete = 1'b0;
    word          = '0;
    spill         = n - free;
    if (n < free) begin
      acc_next  = acc | (v << (free - n));
      free_next = free - n;
    end else if (n == free) begin
      word_complete = 1'b1;
      word          = acc | v;
      acc_next      = '0;
      free_next     = FREE_FULL;
    end else begin
      // spill bits of the chunk start the next word
      word_complete = 1'b1;
      word          = acc | (v >> spill);
      acc_next      = v << (FREE_FULL - spill);
      free_next     = FREE_FULL - spill;
    end
  end

endmodule

// File: rtl/rice_encoder_packer.sv
// Rice encoder: unary quotient + k-bit remainder per sample, packed MSB-first
// into 32-bit words on a valid/ready stream, with flush for the partial word.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | ready for a sample; flush request starts FLUSH
// UNARY   | append q zeros and the terminating '1'
// REM     | append the k remainder bits
// FLUSH   | emit the zero-padded partial word (if any), pulse flush_done
module rice_encoder_packer
  import rice_pkg::*;
#(
  parameter int DW   = 16,
  parameter int KW   = 4,
  parameter int QMAX = 31
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  input  logic [KW-1:0] in_k,
  input  logic          flush,
  output logic          flush_done,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_data,
  output logic          out_last,
  output logic          err
);

  rice_fsm_t         state;
  rice_enc_state_t   samp;
  logic [WORD_W-1:0] acc;
  logic [LEN_W-1:0]  free;

  logic [DW-1:0]     q_full;
  logic [DW-1:0]     r_full;
  logic              q_over;
  logic              slot_free;

  logic [WORD_W-1:0] app_v;
  logic [LEN_W-1:0]  app_n;
  logic [WORD_W-1:0] app_acc;
  logic [LEN_W-1:0]  app_free;
  logic              app_complete;
  logic [WORD_W-1:0] app_word;

  assign in_ready  = (state == S_IDLE);
  assign q_full    = in_data >> in_k;
  assign r_full    = in_data & ~({DW{1'b1}} << in_k);
  assign q_over    = (q_full > DW'(QMAX));
  assign slot_free = !out_valid || out_ready;

  assign app_n = (state == S_UNARY) ? samp.q + LEN_W'(1) : samp.k;
  assign app_v = (state == S_UNARY) ? WORD_W'(1) : samp.r;

  rice_word_appender u_appender (
    .acc           (acc),
    .free          (free),
    .v             (app_v),
    .n             (app_n),
    .acc_next      (app_acc),
    .free_next     (app_free),
    .word_complete (app_complete),
    .word          (app_word)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      samp       <= '0;
      acc        <= '0;
      free       <= FREE_FULL;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_last   <= 1'b0;
      err        <= 1'b0;
      flush_done <= 1'b0;
    end else begin
      err        <= 1'b0;
      flush_done <= 1'b0;
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            samp.q <= q_full[LEN_W-1:0];
            samp.r <= WORD_W'(r_full);
            samp.k <= LEN_W'(in_k);
            if (q_over) begin
              err <= 1'b1;
            end else begin
              state <= S_UNARY;
            end
          end else if (flush && !flush_done) begin
            // flush_done high means this level request was just serviced
            state <= S_FLUSH;
          end
        end
        S_UNARY, S_REM: begin
          if (!app_complete || slot_free) begin
            acc  <= app_acc;
            free <= app_free;
            if (app_complete) begin
              out_data  <= app_word;
              out_valid <= 1'b1;
              out_last  <= 1'b0;
            end
            state <= (state == S_UNARY && samp.k != '0) ? S_REM : S_IDLE;
          end
        end
        S_FLUSH: begin
          if (free == FREE_FULL) begin
            flush_done <= 1'b1;
            state      <= S_IDLE;
          end else if (slot_free) begin
            out_data   <= acc;
            out_valid  <= 1'b1;
            out_last   <= 1'b1;
            acc        <= '0;
            free       <= FREE_FULL;
            flush_done <= 1'b1;
            state      <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rice_encoder_packer.sv
// Scoreboard bench for rice_encoder_packer: a bit-level model queues expected
// words as samples are sent; a negedge monitor pops and compares them.
module tb_rice_encoder_packer;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [3:0]  in_k;
  logic        flush;
  logic        flush_done;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_last;
  logic        err;

  int checks = 0;
  int errors = 0;

  logic [32:0] exp_q[$];
  bit          pend[$];
  logic [31:0] held;
  bit          holding = 0;
  bit          rand_done;

  always #5 clk = ~clk;

  rice_encoder_packer dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_k       (in_k),
    .flush      (flush),
    .flush_done (flush_done),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .err        (err)
  );

  task automatic check_val(input string tag, input logic [32:0] got, input logic [32:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pack_pend();
    logic [31:0] w = '0;
    for (int i = 0; i < pend.size(); i++) w[31-i] = pend[i];
    return w;
  endfunction

  function automatic void model_bit(input bit b);
    pend.push_back(b);
    if (pend.size() == 32) begin
      exp_q.push_back({1'b0, pack_pend()});
      pend.delete();
    end
  endfunction

  function automatic void model_sample(input int value, input int k);
    int q = value >> k;
    if (q > 31) return;
    for (int i = 0; i < q; i++) model_bit(1'b0);
    model_bit(1'b1);
    for (int i = k - 1; i >= 0; i--) model_bit(value[i]);
  endfunction

  function automatic void model_flush();
    if (pend.size() > 0) begin
      exp_q.push_back({1'b1, pack_pend()});
      pend.delete();
    end
  endfunction

  // Output monitor: scoreboard pop and hold-stability under backpressure.
  always @(negedge clk) begin
    if (reset) begin
      holding = 0;
    end else begin
      if (holding) begin
        check_val("hold_valid", 33'(out_valid), 33'd1);
        check_val("hold_stable", 33'(out_data), 33'(held));
      end
      if (out_valid && out_ready) begin
        check_val("word_pending", 33'(exp_q.size() != 0), 33'd1);
        if (exp_q.size() != 0) check_val("word", {out_last, out_data}, exp_q.pop_front());
      end
      holding = out_valid && !out_ready;
      held    = out_data;
    end
  end

  task automatic send(input int value, input int k);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 16'(value);
    in_k     = 4'(k);
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    check_val("accept", 33'(in_ready), 33'd1);
    model_sample(value, k);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check_val("err", 33'(err), 33'((value >> k) > 31));
  endtask

  task automatic do_flush();
    int n = 0;
    @(negedge clk);
    flush = 1'b1;
    model_flush();
    while (!flush_done && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_val("flush_done", 33'(flush_done), 33'd1);
    flush = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (5) @(negedge clk);
    check_val(tag, 33'(exp_q.size()), 33'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_k      = '0;
    flush     = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_val("rst_out_valid", 33'(out_valid), 33'd0);
    check_val("rst_out_data", 33'(out_data), 33'd0);
    check_val("rst_out_last", 33'(out_last), 33'd0);
    check_val("rst_err", 33'(err), 33'd0);
    check_val("rst_flush_done", 33'(flush_done), 33'd0);
    check_val("rst_in_ready", 33'(in_ready), 33'd1);
    reset = 1'b0;

    // 5,k=1 -> 0011, flushed
    send(5, 1);
    do_flush();
    drain("drain_t1");

    // 32 x '1' codes -> one full word, then an empty flush
    repeat (32) send(0, 0);
    drain("drain_t2a");
    do_flush();
    drain("drain_t2b");

    // straddling 32-bit unary chunk
    send(0, 0);
    send(31, 0);
    do_flush();
    drain("drain_t3");

    // oversize quotient dropped, next sample unaffected
    send(64, 1);
    send(1, 0);
    do_flush();
    drain("drain_t4");

    // backpressure: second word stalls until the slot frees
    out_ready = 1'b0;
    repeat (64) send(0, 0);
    repeat (5) @(negedge clk);
    check_val("stall_in_ready", 33'(in_ready), 33'd0);
    check_val("stall_out_valid", 33'(out_valid), 33'd1);
    check_val("stall_queued", 33'(exp_q.size()), 33'd2);
    out_ready = 1'b1;
    drain("drain_t5");

    // reset during REM abandons the sample
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 16'hFFFF;
    in_k     = 4'd15;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check_val("mid_rst_out_valid", 33'(out_valid), 33'd0);
    check_val("mid_rst_out_data", 33'(out_data), 33'd0);
    check_val("mid_rst_out_last", 33'(out_last), 33'd0);
    check_val("mid_rst_err", 33'(err), 33'd0);
    check_val("mid_rst_flush_done", 33'(flush_done), 33'd0);
    check_val("mid_rst_in_ready", 33'(in_ready), 33'd1);
    pend.delete();
    @(negedge clk);
    reset = 1'b0;
    do_flush();
    drain("drain_t6");

    // random samples with random backpressure
    rand_done = 0;
    fork
      begin
        for (int i = 0; i < 40; i++) send(int'($urandom_range(0, 2047)), int'($urandom_range(0, 15)));
        rand_done = 1;
      end
      begin
        while (!rand_done) begin
          @(negedge clk);
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    do_flush();
    drain("drain_rand");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
